// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver, LSB first, with centre-of-bit sampling.
// Presents each good byte with a one-cycle valid strobe; a low stop bit gives a frame-error strobe.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    // state     | meaning
    // IDLE      | line idle, waiting for a low on rxs
    // START     | timing to the centre of the start bit to reject glitches
    // DATA      | sampling eight data bits at their centres
    // STOP      | sampling the stop bit
    // WAIT_IDLE | after a framing error, waiting for the line to return high
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_IDLE = 3'd4;

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    logic        rx_meta;
    logic        rxs;
    logic [2:0]  state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;

    // Reset to 1 so a released reset does not look like a start edge unless rx is really low.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= 16'd0;
                    if (!rxs) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= 16'd0;
                        if (!rxs) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= 16'd0;
                        shift   <= {rxs, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= 16'd0;
                        if (rxs) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                WAIT_IDLE: begin
                    cnt <= 16'd0;
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 16'd0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
